// File: rtl/icache_dm8_if.sv
// Bus bundles for the direct-mapped instruction cache: core fetch side and
// external instruction-memory side.
interface icache_core_if;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        stallreq_o;
  logic        inv_i;
  logic [15:0] miss_cnt_o;

  modport master (
    output rom_ce_i, rom_addr_i, inv_i,
    input  rom_data_o, stallreq_o, miss_cnt_o
  );

  modport slave (
    input  rom_ce_i, rom_addr_i, inv_i,
    output rom_data_o, stallreq_o, miss_cnt_o
  );
endinterface

interface icache_mem_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  modport master (
    output mem_req_o, mem_addr_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o,
    output mem_rdata_i, mem_ack_i
  );
endinterface

// File: rtl/icache_dm8.sv
// 8-entry, one-word-per-line direct-mapped instruction cache with a single
// outstanding refill request and a saturating miss counter.
module icache_dm8 (
  input  logic         clk,
  input  logic         rst,
  icache_core_if.slave core,
  icache_mem_if.master mem
);

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  state_t      state;
  logic [7:0]  valid;
  logic [26:0] tags  [8];
  logic [31:0] words [8];
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [15:0] miss_cnt;

  logic [2:0]  index;
  logic [26:0] tag;
  logic [2:0]  fill_index;
  logic [26:0] fill_tag;
  logic        hit;
  logic        miss;
  logic        fill;
  logic [1:0]  unused_addr_bits;

  assign index            = core.rom_addr_i[4:2];
  assign tag              = core.rom_addr_i[31:5];
  assign fill_index       = mem_addr[4:2];
  assign fill_tag         = mem_addr[31:5];
  assign unused_addr_bits = core.rom_addr_i[1:0];

  assign hit  = core.rom_ce_i && (state == IDLE) && valid[index] && (tags[index] == tag);
  assign miss = core.rom_ce_i && (state == IDLE) && !hit;
  assign fill = (state == REQ) && mem.mem_ack_i;

  // Any non-IDLE state keeps the pipeline held until the refilled word is looked up again.
  assign core.rom_data_o = hit ? words[index] : 32'h0;
  assign core.stallreq_o = rst && ((state != IDLE) || miss);
  assign core.miss_cnt_o = miss_cnt;
  assign mem.mem_req_o   = mem_req;
  assign mem.mem_addr_o  = mem_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      valid    <= '0;
      mem_req  <= 1'b0;
      mem_addr <= 32'h0;
      miss_cnt <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            state    <= REQ;
            mem_req  <= 1'b1;
            mem_addr <= {core.rom_addr_i[31:2], 2'b00};
            if (miss_cnt != 16'hFFFF) begin
              miss_cnt <= miss_cnt + 16'd1;
            end
          end
        end
        REQ: begin
          if (mem.mem_ack_i) begin
            state             <= FILL;
            mem_req           <= 1'b0;
            valid[fill_index] <= 1'b1;
          end
        end
        FILL: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
      // Placed last so a flush overrides a coincident refill of the same edge.
      if (core.inv_i) begin
        valid <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tags[fill_index]  <= fill_tag;
      words[fill_index] <= mem.mem_rdata_i;
    end
  end

endmodule
